// File: rtl/present_pkg.sv
// Shared PRESENT definitions: FSM states, key-schedule constants and the
// 4-bit S-box / 64-bit bit-permutation helpers used by the core and key step.
package present_pkg;

    localparam int ROUND_CTR_W  = 5;
    localparam int CTR_LSB_80   = 15;
    localparam int CTR_LSB_128  = 62;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        WHITEN,
        RUN,
        DONE
    } present_state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'h5;
            4'h1:    y = 4'hE;
            4'h2:    y = 4'hF;
            4'h3:    y = 4'h8;
            4'h4:    y = 4'hC;
            4'h5:    y = 4'h1;
            4'h6:    y = 4'h2;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'hB;
            4'h9:    y = 4'h4;
            4'hA:    y = 4'h6;
            4'hB:    y = 4'h3;
            4'hC:    y = 4'h0;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_sbox_layer64(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 is a fixed point.
    function automatic logic [63:0] player64(input logic [63:0] x);
        logic [63:0] y;
        y     = '0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_player64(input logic [63:0] x);
        logic [63:0] y;
        y     = '0;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            y[i] = x[(i * 16) % 63];
        end
        return y;
    endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// Request/response bundle between the bus-side request buffer (master)
// and the PRESENT core (slave).
interface present_cipher_core_if #(
    parameter int KEY_WIDTH = 80
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [63:0]          in_block;
    logic [KEY_WIDTH-1:0] in_key;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          out_block;
    logic                 busy;

    modport master (
        output in_valid, in_mode, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block, busy
    );

    modport slave (
        input  in_valid, in_mode, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block, busy
    );

endinterface

// File: rtl/present_key_step.sv
// One PRESENT key-register step: forward (rotate, S-box, counter XOR) or
// its exact inverse (counter XOR, inverse S-box, rotate back).
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80
) (
    input  logic [KEY_WIDTH-1:0]   key_i,
    input  logic [ROUND_CTR_W-1:0] ctr_i,
    input  logic                   dir_i,
    output logic [KEY_WIDTH-1:0]   next_key_o
);

    localparam int CTR_LSB = (KEY_WIDTH == 128) ? CTR_LSB_128 : CTR_LSB_80;

    logic [KEY_WIDTH-1:0] rotKey;
    logic [KEY_WIDTH-1:0] fwdKey;
    logic [KEY_WIDTH-1:0] unKey;
    logic [KEY_WIDTH-1:0] invKey;

    always_comb begin
        rotKey = {key_i[KEY_WIDTH-62:0], key_i[KEY_WIDTH-1:KEY_WIDTH-61]};
        fwdKey = rotKey;
        fwdKey[KEY_WIDTH-1 -: 4] = sbox4(rotKey[KEY_WIDTH-1 -: 4]);
        if (KEY_WIDTH == 128) begin
            fwdKey[KEY_WIDTH-5 -: 4] = sbox4(rotKey[KEY_WIDTH-5 -: 4]);
        end
        fwdKey[CTR_LSB +: ROUND_CTR_W] = fwdKey[CTR_LSB +: ROUND_CTR_W] ^ ctr_i;

        // The counter field never overlaps the S-boxed nibbles, so undoing
        // the XOR first is equivalent to undoing it last.
        unKey = key_i;
        unKey[CTR_LSB +: ROUND_CTR_W] = key_i[CTR_LSB +: ROUND_CTR_W] ^ ctr_i;
        unKey[KEY_WIDTH-1 -: 4] = inv_sbox4(key_i[KEY_WIDTH-1 -: 4]);
        if (KEY_WIDTH == 128) begin
            unKey[KEY_WIDTH-5 -: 4] = inv_sbox4(key_i[KEY_WIDTH-5 -: 4]);
        end
        invKey = {unKey[60:0], unKey[KEY_WIDTH-1:61]};

        next_key_o = dir_i ? invKey : fwdKey;
    end

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT-80/128 engine, one round per clock, with run-time
// decrypt mode that rewinds the key schedule on the fly.
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    present_cipher_core_if.slave bus
);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("present_cipher_core: NUM_ROUNDS must be in 1..31");
    end

    localparam logic [ROUND_CTR_W-1:0] LAST_CTR = ROUND_CTR_W'(NUM_ROUNDS);
    localparam logic [ROUND_CTR_W-1:0] FIRST_CTR = ROUND_CTR_W'(1);

    present_state_t         state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ROUND_CTR_W-1:0] ctr_q, ctr_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [63:0]            data_q, data_d;

    logic [KEY_WIDTH-1:0]   stepKey;
    logic                   stepInv;

    assign stepInv = (state_q == RUN) && mode_q;

    present_key_step #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_key_step (
        .key_i      (key_q),
        .ctr_i      (ctr_q),
        .dir_i      (stepInv),
        .next_key_o (stepKey)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            ctr_q   <= '0;
            key_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ctr_q   <= ctr_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ctr_d   = ctr_q;
        key_d   = key_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mode_d = bus.in_mode;
                    key_d  = bus.in_key;
                    ctr_d  = FIRST_CTR;
                    if (bus.in_mode) begin
                        data_d  = bus.in_block;
                        state_d = KEYEXP;
                    end else begin
                        data_d  = bus.in_block ^ bus.in_key[KEY_WIDTH-1 -: 64];
                        state_d = RUN;
                    end
                end
            end

            // Walk the schedule forward to the last round key so decryption
            // can rewind it one step per round.
            KEYEXP: begin
                key_d = stepKey;
                if (ctr_q == LAST_CTR) begin
                    state_d = WHITEN;
                end else begin
                    ctr_d = ctr_q + FIRST_CTR;
                end
            end

            WHITEN: begin
                data_d  = data_q ^ key_q[KEY_WIDTH-1 -: 64];
                state_d = RUN;
            end

            RUN: begin
                key_d = stepKey;
                if (!mode_q) begin
                    data_d = player64(sbox_layer64(data_q)) ^ stepKey[KEY_WIDTH-1 -: 64];
                    if (ctr_q == LAST_CTR) begin
                        state_d = DONE;
                    end else begin
                        ctr_d = ctr_q + FIRST_CTR;
                    end
                end else begin
                    data_d = inv_sbox_layer64(inv_player64(data_q)) ^ stepKey[KEY_WIDTH-1 -: 64];
                    if (ctr_q == FIRST_CTR) begin
                        state_d = DONE;
                    end else begin
                        ctr_d = ctr_q - FIRST_CTR;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_block = (state_q == DONE) ? data_q : 64'd0;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/present_cipher_core.md
Name: present_cipher_core

Overview:
- Iterative PRESENT block-cipher engine: one round per clock, generalised over key size (80/128) and round count.
- Adds a run-time decrypt mode with on-the-fly inverse key schedule, plus valid/ready handshakes on input and output.
- Sits between a bus-side request buffer and the result consumer.
- Reuses the existing 64-bit S-box and pLayer datapath arithmetic.

Parameters:
- KEY_WIDTH, 80, key size. Legal values are 80 and 128; any other value is an elaboration error.
- NUM_ROUNDS, 31, number of S-box/pLayer rounds. Legal range is 1..31; the 5-bit round counter fixes the upper bound.

Ports:
- clk  in  1  system clock. One clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  core can accept a request.
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_block  in  64  plaintext or ciphertext.
- in_key  in  KEY_WIDTH  cipher key.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_block  out  64  result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_block=0, all internal registers 0.
- rst wins over every other event, including mid-operation. The operation in progress is discarded without output.
- Round key K_i is key_reg[KEY_WIDTH-1 -: 64].
- Forward schedule step with counter c:
  - Rotate key_reg left by 61.
  - Apply the S-box to the top nibble; for 128-bit keys, to the top two nibbles.
  - XOR c into bits [19:15] for 80-bit keys, or [66:62] for 128-bit keys.
- Inverse step with counter c undoes the forward step in reverse order: XOR c, apply the inverse S-box, rotate right by 61.
- FSM states: IDLE, KEYEXP, WHITEN, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_mode, load key_reg=in_key and set ctr=1.
  - Encrypt: load state=in_block^K_1 and go to RUN.
  - Decrypt: load state=in_block and go to KEYEXP.
- KEYEXP (decrypt only):
  - Each cycle, apply a forward step with ctr, then ctr++.
  - After NUM_ROUNDS steps, key_reg holds K_{NUM_ROUNDS+1}. Set ctr=NUM_ROUNDS and go to WHITEN.
- WHITEN: state ^= K_{NUM_ROUNDS+1}, then go to RUN.
- RUN, encrypt:
  - Each cycle, apply a forward step with ctr to key_reg, then state <= pLayer(Sbox(state)) ^ K_next. K_next is the top 64 bits of the freshly stepped key.
  - ctr++. Leave after NUM_ROUNDS cycles.
- RUN, decrypt:
  - Each cycle, key_reg <= inverse step with ctr, then state <= invSbox(invPLayer(state)) ^ K_prev.
  - ctr--. Leave after NUM_ROUNDS cycles.
- DONE:
  - out_valid=1 and out_block=state, both held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE. in_ready rises the following cycle; there is no same-cycle overlap.
- Latency from the accept cycle to the first out_valid cycle:
  - Encrypt: NUM_ROUNDS+1 cycles.
  - Decrypt: 2*NUM_ROUNDS+2 cycles.
- Inputs are ignored outside IDLE. in_key and in_block may change freely after acceptance.
- ctr is 5 bits and never wraps within legal NUM_ROUNDS.
- Round function width is fixed at 64 bits. All XORs are bitwise; there are no carries.

Decomposition:
- present_pkg holds:
  - Functions: sbox4, inv_sbox4, player64, inv_player64.
  - Typedef: state enum present_state_t.
  - Constants: counter-insert bit positions for 80- and 128-bit keys, and ROUND_CTR_W=5.
- One sub-module, present_key_step: combinational, parameterised by KEY_WIDTH, with inputs key, ctr and dir and output next_key.
- The datapath round logic stays inline in the core, using the package functions.

Test Plan:
- PRESENT-80 encrypt, key=0, pt=0 -> out_block=0x5579C1387B228445, with out_valid first high 32 cycles after accept.
- PRESENT-80 encrypt, key=all-ones, pt=all-ones -> 0x3333DCD3213210D2. Also key=all-ones, pt=0 -> 0xE72C46C0F5945049.
- PRESENT-128 encrypt, key=0, pt=0 -> 0x96DB702A2E6900AF.
- Decrypt the ciphertexts above with their matching keys -> original plaintext, with out_valid first high 64 cycles after accept. Then run random encrypt/decrypt round-trips with NUM_ROUNDS set to 7 and to 31.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid and out_block are stable and in_ready=0. Pulse in_valid with new data during the stall -> the pulse is ignored.
- Assert rst during RUN at round 12 -> the next cycle shows IDLE with in_ready=1, out_valid=0, busy=0. A new request then completes with the correct vector.
